// File: rtl/radix_multiplier.sv
// Iterative unsigned multiplier: retires DIGIT_BITS multiplier bits per cycle,
// finishes early once the remaining multiplier bits are all zero.
module radix_multiplier #(
  parameter int WIDTH      = 1024,
  parameter int DIGIT_BITS = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic                 square_in,
  input  logic                 start_in,
  input  logic                 abort_in,
  input  logic                 ack_in,
  output logic                 busy_out,
  output logic                 valid_out,
  output logic [2*WIDTH-1:0]   result_out
);

  localparam int OUT_WIDTH = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [OUT_WIDTH-1:0]   mcand;
  logic [OUT_WIDTH-1:0]   acc;
  logic [WIDTH-1:0]       mplier;
  logic [DIGIT_BITS-1:0]  digit;
  logic [OUT_WIDTH-1:0]   partial;

  // The digit is zero-extended, so only the low WIDTH+DIGIT_BITS bits above
  // the current shift position can ever be nonzero.
  assign digit   = mplier[DIGIT_BITS-1:0];
  assign partial = mcand * OUT_WIDTH'(digit);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      busy_out   <= 1'b0;
      valid_out  <= 1'b0;
      result_out <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in && !abort_in) begin
            mcand    <= OUT_WIDTH'(a_in);
            mplier   <= square_in ? a_in : b_in;
            acc      <= '0;
            state    <= RUN;
            busy_out <= 1'b1;
          end
        end
        RUN: begin
          if (abort_in) begin
            state    <= IDLE;
            busy_out <= 1'b0;
          end else if (mplier == '0) begin
            result_out <= acc;
            state      <= DONE;
            busy_out   <= 1'b0;
            valid_out  <= 1'b1;
          end else begin
            acc    <= acc + partial;
            mcand  <= mcand << DIGIT_BITS;
            mplier <= mplier >> DIGIT_BITS;
          end
        end
        DONE: begin
          // A start arriving here is dropped; the consumer re-issues it in IDLE.
          if (ack_in || abort_in) begin
            state     <= IDLE;
            valid_out <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy_out  <= 1'b0;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/radix_multiplier.md
# radix_multiplier

Iterative unsigned multiplier producing a full-width 2·WIDTH product. It retires DIGIT_BITS multiplier bits per cycle, and a square mode reuses operand A as the multiplier. Remaining multiplier bits are zero-detected so the block finishes early. It is the parametrised successor of the team's 1-bit shift-add squaring unit and feeds the modular-exponentiation datapath, which now holds results until they are acknowledged and can cancel an operation in flight.

## Interface
- WIDTH, 1024: operand width in bits; must be a multiple of DIGIT_BITS.
- DIGIT_BITS, 4: multiplier bits consumed per RUN cycle; allowed range 1..8.
- OUT_WIDTH, 2*WIDTH: product width; derived, not to be overridden.
- clk_in  input  1  single clock; all state updates on its rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- a_in  input  WIDTH  multiplicand; sampled only when a start is accepted.
- b_in  input  WIDTH  multiplier; sampled on start, ignored when square_in=1.
- square_in  input  1  1 selects a_in as the multiplier (computes a_in²); sampled on start.
- start_in  input  1  single-cycle request; accepted only in IDLE.
- abort_in  input  1  cancels the operation in RUN, or acknowledges in DONE.
- ack_in  input  1  consumer has taken result_out; meaningful in DONE only.
- busy_out  output  1  high in RUN.
- valid_out  output  1  high in DONE.
- result_out  output  OUT_WIDTH  product; stable while valid_out=1.

## Operation
- States: IDLE, RUN, DONE. Any unreachable encoding returns to IDLE with busy_out=0 and valid_out=0.
- Reset (rst_in=0, asynchronous): state=IDLE, busy_out=0, valid_out=0, result_out=0, internal accumulator, multiplicand and multiplier registers=0.
- IDLE, start_in=1, abort_in=0:
  - latch multiplicand=a_in;
  - latch multiplier=(square_in ? a_in : b_in);
  - clear accumulator;
  - go to RUN; busy_out rises.
- IDLE, start_in=1 and abort_in=1: abort wins; stay in IDLE with nothing latched.
- RUN, each cycle:
  - if multiplier==0: result_out<=accumulator, go to DONE.
  - else: accumulator += multiplicand × multiplier[DIGIT_BITS-1:0]; multiplicand <<= DIGIT_BITS; multiplier >>= DIGIT_BITS.
- Arithmetic width: the multiplicand register is OUT_WIDTH wide. The accumulator is OUT_WIDTH and never overflows because the product is below 2^OUT_WIDTH. The partial product is WIDTH+DIGIT_BITS bits, zero-extended before shifting. The unsigned result equals a×b exactly.
- RUN with abort_in=1: go to IDLE next edge. busy_out falls, valid_out stays 0, result_out keeps its previous value.
- DONE:
  - result_out and valid_out are held indefinitely until ack_in=1 or abort_in=1; that edge returns to IDLE and clears valid_out.
  - start_in is ignored in DONE, including a start in the same cycle as ack_in. The consumer must re-issue the start in IDLE.
- Inputs a_in, b_in and square_in may change freely after the start cycle.

## Timing
- Let k be the number of DIGIT_BITS digits of the multiplier up to and including its highest nonzero digit; k=0 for a zero multiplier.
- Cycles in RUN: k+1. The worst case is WIDTH/DIGIT_BITS+1.
- Start accepted at edge E0:
  - busy_out=1 from E0 to E0+k+1;
  - valid_out=1 from E0+k+1;
  - busy_out and valid_out are never high together.
- Minimum issue interval is k+3 cycles: RUN, then a DONE cycle with ack_in=1, then the start in IDLE.
- Reset asserted mid-RUN or in DONE: outputs go to their reset values immediately, without waiting for a clock edge. Deassertion is synchronised externally.

## Test plan
- Configuration for all scenarios: WIDTH=16, DIGIT_BITS=4.
- a=0x00FF, b=0x0003, square=0 -> 2 RUN cycles, then valid_out=1 with result_out=0x000002FD; busy_out is high for exactly 2 cycles.
- a=0xFFFF, b=0xFFFF -> 5 RUN cycles, result_out=0xFFFE0001. Hold ack_in=0 for 10 cycles: valid_out and result_out stay unchanged. Then ack_in=1 -> IDLE with valid_out=0 on the next edge.
- square=1, a=0x1234, b=0xBEEF -> b is ignored, 5 RUN cycles, result_out=0x014B5A90.
- b=0x0000 -> 1 RUN cycle, result_out=0x00000000.
- Boundary: b=0x8000 -> 5 RUN cycles. b=0x0010 -> 3 RUN cycles.
- Abort and reset:
  - abort_in=1 during the 3rd RUN cycle of 0xFFFF×0xFFFF -> IDLE next edge, valid_out never rises, result_out keeps its prior value.
  - start_in with abort_in in IDLE -> no start.
  - start_in during DONE -> ignored.
  - rst_in=0 mid-RUN -> busy_out=0, valid_out=0, result_out=0 asynchronously.
